// File: rtl/lz77_pkg.sv
// Shared state encoding and default parameter set for the LZ77 decoder.
// Pure declarations; no logic, latency or flow control of its own.
package lz77_pkg;

    localparam int         SB_DEPTH_DEF = 9;
    localparam int         POS_W_DEF    = 4;
    localparam int         LEN_W_DEF    = 3;
    localparam int         CHAR_W_DEF   = 8;
    localparam logic [7:0] END_CHAR_DEF = 8'h24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        LIT  = 2'd2,
        DONE = 2'd3
    } lz77_state_e;

endpackage

// File: rtl/lz77_search_buf.sv
// Search buffer: shift register of recently emitted characters, entry 0 newest.
// Shift takes effect on the clock edge; read port is combinational. No backpressure.
module lz77_search_buf
    import lz77_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEF,
    parameter int IDX_W = POS_W_DEF,
    parameter int DAT_W = CHAR_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en_i,
    input  logic [DAT_W-1:0] shift_dat_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [DAT_W-1:0] rd_dat_o
);

    logic [DAT_W-1:0] sb_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                sb_q[i] <= '0;
            end
        end else if (shift_en_i) begin
            sb_q[0] <= shift_dat_i;
            for (int i = 1; i < DEPTH; i++) begin
                sb_q[i] <= sb_q[i-1];
            end
        end
    end

    // Out-of-range indices read as zero rather than X.
    always_comb begin
        rd_dat_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(rd_idx_i) == i) begin
                rd_dat_o = sb_q[i];
            end
        end
    end

endmodule

// File: rtl/lz77_decoder_p.sv
// LZ77 decoder: each (pos,len,char) codeword yields len copied chars then the literal.
// First char one cycle after acceptance, len+1 back-to-back chars; code_ready low while copying or done.
module lz77_decoder_p
    import lz77_pkg::*;
#(
    parameter int                SB_DEPTH = SB_DEPTH_DEF,
    parameter int                POS_W    = POS_W_DEF,
    parameter int                LEN_W    = LEN_W_DEF,
    parameter int                CHAR_W   = CHAR_W_DEF,
    parameter logic [CHAR_W-1:0] END_CHAR = CHAR_W'(END_CHAR_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic [POS_W-1:0]  code_pos,
    input  logic [LEN_W-1:0]  code_len,
    input  logic [CHAR_W-1:0] chardata,
    output logic              char_valid,
    output logic [CHAR_W-1:0] char_nxt,
    output logic              finish
);

    // state_q names the cycle currently on the outputs; the emitted character
    // is computed and shifted into the buffer on the edge entering that cycle.
    lz77_state_e       state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [CHAR_W-1:0] lit_q, lit_d;
    logic              vld_q, vld_d;
    logic [CHAR_W-1:0] dat_q, dat_d;
    logic              fin_q, fin_d;
    logic              rdy_q, rdy_d;

    logic              accept;
    logic [POS_W-1:0]  pos_clamp;
    logic [POS_W-1:0]  rd_idx;
    logic [CHAR_W-1:0] rd_dat;
    logic              emit_copy;
    logic              emit_lit;
    logic [CHAR_W-1:0] lit_sel;

    assign accept    = code_valid && rdy_q;
    assign pos_clamp = (int'(code_pos) >= SB_DEPTH) ? POS_W'(SB_DEPTH - 1) : code_pos;
    assign rd_idx    = accept ? pos_clamp : pos_q;

    lz77_search_buf #(
        .DEPTH (SB_DEPTH),
        .IDX_W (POS_W),
        .DAT_W (CHAR_W)
    ) u_sbuf (
        .clk         (clk),
        .reset       (reset),
        .shift_en_i  (vld_d),
        .shift_dat_i (dat_d),
        .rd_idx_i    (rd_idx),
        .rd_dat_o    (rd_dat)
    );

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        rem_d     = rem_q;
        lit_d     = lit_q;
        emit_copy = 1'b0;
        emit_lit  = 1'b0;
        lit_sel   = lit_q;

        case (state_q)
            IDLE, LIT: begin
                if (fin_q) begin
                    state_d = DONE;
                end else if (accept) begin
                    pos_d = pos_clamp;
                    lit_d = chardata;
                    if (code_len != '0) begin
                        emit_copy = 1'b1;
                        rem_d     = code_len - LEN_W'(1);
                        state_d   = COPY;
                    end else begin
                        emit_lit = 1'b1;
                        lit_sel  = chardata;
                        state_d  = LIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            COPY: begin
                if (rem_q != '0) begin
                    emit_copy = 1'b1;
                    rem_d     = rem_q - LEN_W'(1);
                end else begin
                    emit_lit = 1'b1;
                    state_d  = LIT;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        vld_d = emit_copy || emit_lit;
        if (emit_copy) begin
            dat_d = rd_dat;
        end else if (emit_lit) begin
            dat_d = lit_sel;
        end else begin
            dat_d = dat_q;
        end

        // The cycle carrying END_CHAR already refuses new codewords, so none is swallowed.
        fin_d = fin_q || (emit_lit && (lit_sel == END_CHAR));
        rdy_d = !fin_d && ((state_d == IDLE) || (state_d == LIT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pos_q   <= '0;
            rem_q   <= '0;
            lit_q   <= '0;
            vld_q   <= 1'b0;
            dat_q   <= '0;
            fin_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            rem_q   <= rem_d;
            lit_q   <= lit_d;
            vld_q   <= vld_d;
            dat_q   <= dat_d;
            fin_q   <= fin_d;
            rdy_q   <= rdy_d;
        end
    end

    assign code_ready = rdy_q;
    assign char_valid = vld_q;
    assign char_nxt   = dat_q;
    assign finish     = fin_q;

endmodule

// File: doc/lz77_decoder_p.md
LZ77_DECODER_P -- requirements
Module: lz77_decoder_p

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and reset.
REQ-002 Parameter SB_DEPTH, default 9: search-buffer depth in characters.
REQ-003 Parameter POS_W, default 4: code_pos width; SHALL satisfy 2^POS_W >= SB_DEPTH.
REQ-004 Parameter LEN_W, default 3: code_len width; maximum copy length is 2^LEN_W-1.
REQ-005 Parameter CHAR_W, default 8: character width.
REQ-006 Parameter END_CHAR, default 8'h24 ('$'): terminating literal.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 code_valid  input  1  codeword present on code_pos/code_len/chardata.
REQ-010 code_ready  output  1  block accepts a codeword this cycle.
REQ-011 code_pos  input  POS_W  match offset; 0 = most recently emitted character.
REQ-012 code_len  input  LEN_W  number of characters to copy.
REQ-013 chardata  input  CHAR_W  literal emitted after the copy.
REQ-014 char_valid  output  1  char_nxt holds a decoded character this cycle.
REQ-015 char_nxt  output  CHAR_W  decoded character.
REQ-016 finish  output  1  END_CHAR emitted; decoding complete.

Function
REQ-017 The FSM SHALL have states IDLE, COPY, LIT and DONE; all outputs SHALL be registered.
REQ-018 A codeword SHALL be accepted on a rising edge where code_valid and code_ready are both 1; pos, len and char SHALL be latched on that edge.
REQ-019 code_ready SHALL be 1 in IDLE and in LIT, and 0 in COPY and DONE.
REQ-020 On acceptance, the next state SHALL be COPY when len > 0, else LIT.
REQ-021 In COPY, each cycle SHALL drive char_nxt = buf[pos] with char_valid = 1, then shift that character into buf[0] (older entries move up, buf[SB_DEPTH-1] is dropped) and decrement the remaining count. The state SHALL go to LIT after the len-th character.
REQ-022 Reading buf[pos] during the shift SHALL give correct overlapping copies when len > pos+1 (for example, pos=0 repeats the last character).
REQ-023 In LIT, the block SHALL drive char_nxt = latched char with char_valid = 1 and shift it into the buffer. The next state SHALL be:
  - DONE if char == END_CHAR;
  - else COPY or LIT if a new codeword is accepted in the same cycle (back-to-back, no bubble);
  - else IDLE.
REQ-024 Each codeword SHALL produce exactly len+1 char_valid cycles, the first one in the cycle after acceptance.
REQ-025 In IDLE, char_valid SHALL be 0 and char_nxt SHALL hold its last value.
REQ-026 finish SHALL rise in the same cycle as the char_valid that carries END_CHAR. It SHALL stay 1 in DONE until reset, and code_valid SHALL be ignored while in DONE.
REQ-027 A code_pos >= SB_DEPTH SHALL be clamped to SB_DEPTH-1.
REQ-028 Buffer entries not yet written SHALL read as 0.

Reset
REQ-029 While reset = 1, the block SHALL force:
  - state = IDLE and all buffer entries = 0;
  - char_valid = 0, char_nxt = 0, finish = 0;
  - code_ready = 0 while reset is held, rising to 1 in the first cycle after release.
REQ-030 Reset asserted mid-COPY or mid-LIT SHALL discard the in-flight codeword with no further char_valid.

Structure
REQ-031 The state encoding and the default parameter constants SHALL live in the shared package lz77_pkg.
REQ-032 The search buffer (parametrised shift register with an indexed read port) SHALL be the sub-module lz77_search_buf; the FSM and counters SHALL stay in lz77_decoder_p.

Verification
REQ-033 Reset release: code_ready = 1, char_valid = 0, finish = 0, char_nxt = 0.
REQ-034 Literal only: (pos=0, len=0, char=8'h61) -> one cycle with char_valid = 1 and char_nxt = 8'h61, then IDLE.
REQ-035 Copy: after emitting 'a','b','c', send (pos=2, len=3, char='d') -> four consecutive cycles 8'h61, 8'h62, 8'h63, 8'h64.
REQ-036 Overlap plus back-to-back: after 'a', send (pos=0, len=4, char='b') and hold code_valid with (pos=1, len=1, char='c') -> the second codeword is accepted in the LIT cycle, and the output is a,a,a,a,b,a,c with no gap.
REQ-037 Terminate: (pos=0, len=0, char=8'h24) -> char_nxt = 8'h24 with char_valid = 1 and finish = 1 in the same cycle; finish stays 1, code_ready stays 0, and later codewords are ignored.
REQ-038 Reset mid-COPY, plus a rerun with SB_DEPTH=16: reset during (pos=5, len=7) -> char_valid = 0 and buffer reads 0. With SB_DEPTH=16, (pos=15, len=2) copies the correct oldest entries.
